cbus_sram_slave: RTL and testbench
==================================

# cbus_sram_slave

Cache-bus responder that services `cbus_req_t` requests from DCache/ICache and uncached paths. It is backed by an on-chip byte-strobed word SRAM. It handles single and wrap-around bursts with a configurable first-beat latency, and drives `cbus_resp_t` ready/last/data per beat. It sits on the memory side of the cache bus as the simulation and FPGA stand-in for the AXI bridge.

## Interface
- `MEM_WORDS`, 4096: SRAM depth in 32-bit words; power of two. `IDX_BITS = $clog2(MEM_WORDS)`.
- `LATENCY`, 2: idle cycles between request acceptance and the first beat; 0–15.
- `clk`  in  1: sole clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `creq`  in  `cbus_req_t`: valid, is_write, size, addr, strobe, data, len.
- `cresp`  out  `cbus_resp_t`: ready, last, data.

## Operation
- **States:** IDLE, WAIT, BURST.
- **Accept (IDLE, `creq.valid`=1):**
  - Latch `addr`, `len`, `is_write`.
  - Clear the beat counter and load the latency counter with `LATENCY`.
  - Go to WAIT, or to BURST when `LATENCY`=0.
- **WAIT:** decrement the latency counter each cycle; on reaching 1, go to BURST.
- **BURST:**
  - `cresp.ready = creq.valid` (subject to the Configuration stall).
  - `cresp.last = ready && beat == len_q`.
  - Beat count is `len_q+1`: MLEN1=0, MLEN2=1, MLEN4=3, MLEN8=7, MLEN16=15.
- **Beat address (word index):**
  - `base = addr_q[IDX_BITS+1:2]`; `mask = len_q` (4 bits).
  - `idx = (base & ~mask) | ((base + beat) & mask)`. This wraps within a burst-aligned window, matching the cache critical-word-first refill.
  - Address bits above `IDX_BITS+1` are ignored, so addresses alias modulo the SRAM size.
- **Read beat:** `cresp.data = mem[idx]` when ready, else 0. The full word is returned regardless of `size`; the initiator extracts bytes.
- **Write beat:**
  - On a ready cycle, write the byte lanes of `creq.data` enabled by `creq.strobe` into `mem[idx]`.
  - `size` is not checked; `strobe` is authoritative.
- **Beat advance:** on each ready cycle, `beat++`. When last is asserted, return to IDLE.
- **Abort:** `creq.valid` falling mid-burst, in WAIT or BURST, returns the block to IDLE on the next edge. No ready is asserted and partial writes are kept.
- **Initiator obligation:** the initiator holds `addr/len/is_write` stable for the whole transaction. A request still valid in the cycle after last is treated as a new transaction.

## Timing
- **Reset values:** state=IDLE, `cresp.ready`=0, `cresp.last`=0, `cresp.data`=0, counters=0.
- **Memory:** contents are not reset and persist across reset.
- **Reset mid-transaction:** immediate return to IDLE; a write already committed stays committed.
- **Read latency:** `valid` seen in IDLE at cycle t gives the first ready at t+1+`LATENCY`. Subsequent beats arrive back-to-back.
- **Outputs:** ready, last and data are combinational from registered state plus `creq.valid`. The SRAM read is asynchronous (register array).
- **Write commit:** the write commits on the same edge as the ready beat.
- **Minimum gap:** at least one IDLE cycle between transactions, so back-to-back requests cost `LATENCY`+1 cycles each.

## Configuration
- `CBUS_SRAM_BACKPRESSURE_EN` defined:
  - A 16-bit LFSR (taps 16,14,13,11; seed 16'hACE1 on reset) steps every cycle.
  - In BURST, ready is forced low whenever `lfsr[0]`=1. This stresses initiators that assume back-to-back beats.
  - beat, last and the write commit only occur on cycles where ready is high.
- Undefined: no LFSR; ready is asserted on every BURST cycle in which valid is high.

## Structure
- `cbus_req_t`, `cbus_resp_t`, `MLEN*`, `MSIZE*` stay in the shared `common.svh` package.
- The local state enum `cbus_sram_state_t` is added to the shared package for bench visibility.
- One sub-module, `sram_word_array`: a `MEM_WORDS`×32 array with asynchronous read, synchronous 4-bit byte-strobe write and no reset.

## Test plan
- Single write, then read:
  - Write addr 32'h0000_0040, len MLEN1, strobe 4'b1111, data 32'hDEAD_BEEF.
  - Read it back with strobe 0.
  - Expect the read to return 32'hDEAD_BEEF, with ready=last=1 at cycle t+3 for `LATENCY`=2.
- Wrap burst:
  - Preload words 0x10–0x13 (byte addresses 0x40–0x4C) with 1,2,3,4.
  - Read addr 0x48, len MLEN4.
  - Expect data sequence 3,4,1,2 on 4 consecutive ready beats, with last only on the 4th.
- Strobe merge:
  - Preload word 32'h1122_3344.
  - Write strobe 4'b0101 with data 32'hAABB_CCDD.
  - Expect readback 32'h11BB_33DD.
- Abort:
  - Drop valid after beat 2 of an MLEN8 write.
  - Expect ready low from the next cycle, state IDLE, beats 0–1 written and beats 2–7 unchanged.
- Reset mid-burst:
  - Assert reset asynchronously during beat 1 of an MLEN16 read.
  - Expect ready, last and data to go to 0 immediately.
  - Expect a following MLEN1 read to complete normally.
- Backpressure (`CBUS_SRAM_BACKPRESSURE_EN` defined):
  - Issue an MLEN16 read.
  - Expect exactly 16 ready beats carrying correctly ordered data, with last on the 16th, despite interleaved stalls.

Source files
------------

// File: rtl/cbus_sram_slave_pkg.sv
// cbus_sram_slave_pkg: cache-bus request/response bundles, burst length
// and size codes, responder state enum and the backpressure LFSR step.
package cbus_sram_slave_pkg;

  localparam logic [3:0] MLEN1  = 4'd0;
  localparam logic [3:0] MLEN2  = 4'd1;
  localparam logic [3:0] MLEN4  = 4'd3;
  localparam logic [3:0] MLEN8  = 4'd7;
  localparam logic [3:0] MLEN16 = 4'd15;

  localparam logic [1:0] MSIZE1 = 2'd0;
  localparam logic [1:0] MSIZE2 = 2'd1;
  localparam logic [1:0] MSIZE4 = 2'd2;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        ready;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_BURST
  } cbus_sram_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Fibonacci LFSR, taps 16,14,13,11, shifting right.
  function automatic logic [15:0] lfsr_step(
    input logic [15:0] s
  );
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/cbus_sram_slave_sram.sv
// sram_word_array: MEM_WORDS x 32 register array, async read,
// byte-strobed sync write, no reset. Ports: clk, we, idx, wstrb, wdata, rdata.
module sram_word_array #(
  parameter int MEM_WORDS = 4096,
  parameter int IDX_BITS  = $clog2(MEM_WORDS)
) (
  input  logic                clk,
  input  logic                we,
  input  logic [IDX_BITS-1:0] idx,
  input  logic [3:0]          wstrb,
  input  logic [31:0]         wdata,
  output logic [31:0]         rdata
);

  logic [31:0] mem [MEM_WORDS];

  assign rdata = mem[idx];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < 4; b++) begin
        if (wstrb[b]) begin
          mem[idx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/cbus_sram_slave.sv
// cbus_sram_slave: cache-bus responder backed by a byte-strobed word SRAM,
// wrap bursts with LATENCY idle cycles before the first beat.
// Ports: clk, reset (async, active-high), creq (request), cresp (response).
// Optional: CBUS_SRAM_BACKPRESSURE_EN inserts LFSR-driven ready stalls.
module cbus_sram_slave
  import cbus_sram_slave_pkg::*;
#(
  parameter int MEM_WORDS = 4096,
  parameter int LATENCY   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  cbus_req_t  creq,
  output cbus_resp_t cresp
);

  localparam int         IDX_BITS = $clog2(MEM_WORDS);
  localparam logic [3:0] LAT      = 4'(LATENCY);
  localparam bit         LAT_ZERO = (LATENCY == 0);

  cbus_sram_state_t      state_q, state_d;
  logic [IDX_BITS-1:0]   base_q, base_d;
  logic [3:0]            len_q, len_d;
  logic                  wr_q, wr_d;
  logic [3:0]            beat_q, beat_d;
  logic [3:0]            lat_q, lat_d;

  logic                  stall;
  logic                  ready;
  logic                  last;
  logic [IDX_BITS-1:0]   mask;
  logic [IDX_BITS-1:0]   beat_ext;
  logic [IDX_BITS-1:0]   idx;
  logic [31:0]           rdata;

`ifdef CBUS_SRAM_BACKPRESSURE_EN
  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_step(lfsr_q);
  end

  assign stall = lfsr_q[0];
`else
  assign stall = 1'b0;
`endif

  assign ready = (state_q == S_BURST) && creq.valid && !stall;
  assign last  = ready && (beat_q == len_q);

  // Wrap inside the len-aligned window: critical word first.
  assign mask     = {{(IDX_BITS-4){1'b0}}, len_q};
  assign beat_ext = {{(IDX_BITS-4){1'b0}}, beat_q};
  assign idx      = (base_q & ~mask) | ((base_q + beat_ext) & mask);

  sram_word_array #(
    .MEM_WORDS(MEM_WORDS),
    .IDX_BITS (IDX_BITS)
  ) u_mem (
    .clk  (clk),
    .we   (ready && wr_q),
    .idx  (idx),
    .wstrb(creq.strobe),
    .wdata(creq.data),
    .rdata(rdata)
  );

  assign cresp.ready = ready;
  assign cresp.last  = last;
  assign cresp.data  = (ready && !wr_q) ? rdata : 32'h0;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    wr_d    = wr_q;
    beat_d  = beat_q;
    lat_d   = lat_q;
    unique case (state_q)
      S_IDLE: begin
        if (creq.valid) begin
          base_d  = creq.addr[IDX_BITS+1:2];
          len_d   = creq.len;
          wr_d    = creq.is_write;
          beat_d  = 4'd0;
          lat_d   = LAT;
          state_d = LAT_ZERO ? S_BURST : S_WAIT;
        end
      end
      S_WAIT: begin
        if (!creq.valid) begin
          state_d = S_IDLE;
        end else begin
          lat_d = lat_q - 4'd1;
          if (lat_q <= 4'd1) state_d = S_BURST;
        end
      end
      S_BURST: begin
        if (!creq.valid) begin
          state_d = S_IDLE;
        end else if (ready) begin
          beat_d = beat_q + 4'd1;
          if (last) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      len_q   <= '0;
      wr_q    <= 1'b0;
      beat_q  <= '0;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      len_q   <= len_d;
      wr_q    <= wr_d;
      beat_q  <= beat_d;
      lat_q   <= lat_d;
    end
  end

  // Size and out-of-range address bits are deliberately ignored.
  logic unused_ok;
  assign unused_ok = ^{creq.size, creq.addr[1:0],
                       creq.addr[31:IDX_BITS+2]};

endmodule

// File: tb/tb_cbus_sram_slave.sv
// tb_cbus_sram_slave: scoreboard bench for cbus_sram_slave.
// Expected read words are queued at issue time and popped per ready beat.
module tb_cbus_sram_slave;
  import cbus_sram_slave_pkg::*;

  localparam int LAT = 2;

  logic       clk = 1'b0;
  logic       reset;
  cbus_req_t  creq;
  cbus_resp_t cresp;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [int];
  logic [31:0] exp_q [$];
  bit          exp_last_q [$];
  logic [31:0] got_q [$];
  bit          mon_en = 1'b0;
  logic [31:0] mon_e;
  bit          mon_l;

  always #5 clk = ~clk;

  cbus_sram_slave #(
    .MEM_WORDS(4096),
    .LATENCY  (LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .creq (creq),
    .cresp(cresp)
  );

  function automatic int widx(
    input logic [31:0] addr,
    input logic [3:0]  len,
    input int          k
  );
    int base, n, start;
    base  = int'(addr[13:2]);
    n     = int'(len) + 1;
    start = base - (base % n);
    return start + ((base % n + k) % n);
  endfunction

  always @(negedge clk) begin
    if (mon_en && !reset) begin
      if (cresp.ready && !creq.is_write) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL rd_unexpected got=%h required=none",
                   cresp.data);
        end else begin
          mon_e = exp_q.pop_front();
          mon_l = exp_last_q.pop_front();
          got_q.push_back(cresp.data);
          if (cresp.data !== mon_e) begin
            failures++;
            $display("FAIL rd_data got=%h required=%h",
                     cresp.data, mon_e);
          end
          checks++;
          if (cresp.last !== mon_l) begin
            failures++;
            $display("FAIL rd_last got=%b required=%b",
                     cresp.last, mon_l);
          end
        end
      end else if (!cresp.ready) begin
        checks++;
        if (cresp.data !== 32'h0 || cresp.last !== 1'b0) begin
          failures++;
          $display("FAIL idle_out data=%h last=%b required=0/0",
                   cresp.data, cresp.last);
        end
      end
    end
  end

  task automatic wr_burst(
    input  logic [31:0] addr,
    input  logic [3:0]  len,
    input  logic [3:0]  strb,
    input  logic [31:0] dbase,
    input  int          stop_after,
    output int          nb
  );
    int   c;
    bit   done;
    int   i;
    logic [31:0] old;
    nb = 0; c = 0; done = 0;
    @(posedge clk); #1;
    creq.valid    = 1'b1;
    creq.is_write = 1'b1;
    creq.size     = MSIZE4;
    creq.addr     = addr;
    creq.len      = len;
    creq.strobe   = strb;
    creq.data     = dbase;
    while (!done && c < 400) begin
      @(negedge clk);
      if (cresp.ready) begin
        i   = widx(addr, len, nb);
        old = model.exists(i) ? model[i] : 32'hx;
        for (int b = 0; b < 4; b++)
          if (strb[b]) old[8*b +: 8] = creq.data[8*b +: 8];
        model[i] = old;
        nb++;
        if (cresp.last) done = 1;
      end
      @(posedge clk); #1;
      c++;
      if (done || nb == stop_after) done = 1;
      else creq.data = dbase + 32'(nb);
    end
    creq.valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL wr_timeout beats=%0d required=%0d",
               nb, int'(len) + 1);
    end
  endtask

  task automatic rd_burst(
    input  logic [31:0] addr,
    input  logic [3:0]  len,
    output int          first,
    output int          lastc,
    output int          nb
  );
    int c;
    bit done;
    for (int k = 0; k <= int'(len); k++) begin
      exp_q.push_back(model[widx(addr, len, k)]);
      exp_last_q.push_back(k == int'(len));
    end
    first = -1; lastc = -1; nb = 0; c = 0; done = 0;
    @(posedge clk); #1;
    creq.valid    = 1'b1;
    creq.is_write = 1'b0;
    creq.size     = MSIZE4;
    creq.addr     = addr;
    creq.len      = len;
    creq.strobe   = 4'b0000;
    creq.data     = 32'h0;
    while (!done && c < 400) begin
      @(negedge clk);
      if (cresp.ready) begin
        if (first < 0) first = c;
        lastc = c;
        nb++;
        if (cresp.last) done = 1;
      end
      @(posedge clk); #1;
      c++;
    end
    creq.valid = 1'b0;
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL rd_timeout beats=%0d required=%0d",
               nb, int'(len) + 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    creq  = '0;
    @(posedge clk); #1;
    checks++;
    if (cresp.ready !== 1'b0 || cresp.last !== 1'b0) begin
      failures++;
      $display("FAIL reset_rdy_last got=%b%b required=00",
               cresp.ready, cresp.last);
    end
    checks++;
    if (cresp.data !== 32'h0) begin
      failures++;
      $display("FAIL reset_data got=%h required=0", cresp.data);
    end
    checks++;
    if (dut.state_q !== S_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d required=%0d",
               dut.state_q, S_IDLE);
    end
    checks++;
    if (dut.beat_q !== 4'd0 || dut.lat_q !== 4'd0) begin
      failures++;
      $display("FAIL reset_cnt got=%0d/%0d required=0/0",
               dut.beat_q, dut.lat_q);
    end
    @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    int nb, first, lastc;
    wr_burst(32'h40, MLEN1, 4'hF, 32'hDEAD_BEEF, -1, nb);
    checks++;
    if (nb != 1) begin
      failures++;
      $display("FAIL single_wr_beats got=%0d required=1", nb);
    end
    got_q.delete();
    rd_burst(32'h40, MLEN1, first, lastc, nb);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL single_rd got=%h required=deadbeef",
               got_q.size() ? got_q[0] : 32'hx);
    end
`ifndef CBUS_SRAM_BACKPRESSURE_EN
    checks++;
    if (first != 1 + LAT) begin
      failures++;
      $display("FAIL single_latency got=%0d required=%0d",
               first, 1 + LAT);
    end
`endif
  endtask

  task automatic test_wrap();
    int nb, first, lastc;
    logic [31:0] want [4];
    want = '{32'd3, 32'd4, 32'd1, 32'd2};
    wr_burst(32'h40, MLEN4, 4'hF, 32'd1, -1, nb);
    got_q.delete();
    rd_burst(32'h48, MLEN4, first, lastc, nb);
    checks++;
    if (nb != 4 || got_q.size() != 4) begin
      failures++;
      $display("FAIL wrap_beats got=%0d required=4", nb);
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (got_q[k] !== want[k]) begin
          failures++;
          $display("FAIL wrap_order beat=%0d got=%h required=%h",
                   k, got_q[k], want[k]);
        end
      end
    end
`ifndef CBUS_SRAM_BACKPRESSURE_EN
    checks++;
    if (first != 1 + LAT || lastc - first != 3) begin
      failures++;
      $display("FAIL wrap_timing got=%0d..%0d required=%0d..%0d",
               first, lastc, 1 + LAT, 4 + LAT);
    end
`endif
  endtask

  task automatic test_strobe();
    int nb, first, lastc;
    wr_burst(32'h80, MLEN1, 4'hF, 32'h1122_3344, -1, nb);
    wr_burst(32'h80, MLEN1, 4'b0101, 32'hAABB_CCDD, -1, nb);
    got_q.delete();
    rd_burst(32'h80, MLEN1, first, lastc, nb);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h11BB_33DD) begin
      failures++;
      $display("FAIL strobe_merge got=%h required=11bb33dd",
               got_q.size() ? got_q[0] : 32'hx);
    end
  endtask

  task automatic test_abort();
    int nb, first, lastc;
    logic [31:0] want [8];
    want = '{32'hB0, 32'hB1, 32'hA2, 32'hA3,
             32'hA4, 32'hA5, 32'hA6, 32'hA7};
    wr_burst(32'h100, MLEN8, 4'hF, 32'hA0, -1, nb);
    wr_burst(32'h100, MLEN8, 4'hF, 32'hB0, 2, nb);
    checks++;
    if (nb != 2) begin
      failures++;
      $display("FAIL abort_beats got=%0d required=2", nb);
    end
    @(negedge clk);
    checks++;
    if (cresp.ready !== 1'b0) begin
      failures++;
      $display("FAIL abort_ready got=%b required=0", cresp.ready);
    end
    @(posedge clk); #1;
    checks++;
    if (dut.state_q !== S_IDLE) begin
      failures++;
      $display("FAIL abort_state got=%0d required=%0d",
               dut.state_q, S_IDLE);
    end
    got_q.delete();
    rd_burst(32'h100, MLEN8, first, lastc, nb);
    checks++;
    if (got_q.size() != 8) begin
      failures++;
      $display("FAIL abort_rd_beats got=%0d required=8", got_q.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        checks++;
        if (got_q[k] !== want[k]) begin
          failures++;
          $display("FAIL abort_mem beat=%0d got=%h required=%h",
                   k, got_q[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int nb, first, lastc, c;
    wr_burst(32'h200, MLEN16, 4'hF, 32'h100, -1, nb);
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(model[widx(32'h200, MLEN16, k)]);
      exp_last_q.push_back(k == 15);
    end
    @(posedge clk); #1;
    creq.valid    = 1'b1;
    creq.is_write = 1'b0;
    creq.addr     = 32'h200;
    creq.len      = MLEN16;
    creq.strobe   = 4'b0;
    nb = 0; c = 0;
    while (nb < 2 && c < 400) begin
      @(negedge clk);
      if (cresp.ready) nb++;
      c++;
    end
    checks++;
    if (nb != 2) begin
      failures++;
      $display("FAIL rstmid_beat1 got=%0d required=2", nb);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (cresp.ready !== 1'b0 || cresp.last !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_ctrl got=%b%b required=00",
               cresp.ready, cresp.last);
    end
    checks++;
    if (cresp.data !== 32'h0) begin
      failures++;
      $display("FAIL rstmid_data got=%h required=0", cresp.data);
    end
    creq.valid = 1'b0;
    exp_q.delete();
    exp_last_q.delete();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    got_q.delete();
    rd_burst(32'h204, MLEN1, first, lastc, nb);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 32'h101) begin
      failures++;
      $display("FAIL rstmid_after got=%h required=00000101",
               got_q.size() ? got_q[0] : 32'hx);
    end
`ifndef CBUS_SRAM_BACKPRESSURE_EN
    checks++;
    if (first != 1 + LAT) begin
      failures++;
      $display("FAIL rstmid_latency got=%0d required=%0d",
               first, 1 + LAT);
    end
`endif
  endtask

`ifdef CBUS_SRAM_BACKPRESSURE_EN
  task automatic test_backpressure();
    int nb, first, lastc;
    got_q.delete();
    rd_burst(32'h208, MLEN16, first, lastc, nb);
    checks++;
    if (nb != 16 || got_q.size() != 16) begin
      failures++;
      $display("FAIL bp_beats got=%0d required=16", nb);
    end else begin
      for (int k = 0; k < 16; k++) begin
        checks++;
        if (got_q[k] !== 32'h100 + 32'((2 + k) % 16)) begin
          failures++;
          $display("FAIL bp_order beat=%0d got=%h required=%h",
                   k, got_q[k], 32'h100 + 32'((2 + k) % 16));
        end
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_wrap();
    test_strobe();
    test_abort();
    test_reset_mid();
`ifdef CBUS_SRAM_BACKPRESSURE_EN
    test_backpressure();
`endif
    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
